recovery_state_store: RTL
=========================

# recovery_state_store

Register-save buffer that captures a processor checkpoint (x1..x31 plus PC) into a 32-word save area and serves it to the core's data bus. It is the write-side counterpart of the recovery code ROM: it walks the register file through a read port, stores each value at a fixed word offset, and answers word reads that the recovery routine issues to reload x1..x31. It sits between the core's register file, the fault/checkpoint controller and the data bus, mapped at `SAVE_BASE`.

## Interface

- `SAVE_BASE`, default 32'h1000_0080, byte base of the save window; must be 128-byte aligned.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-high reset.
- `ckpt_req_i`  in  1  checkpoint request; accepted only in IDLE.
- `pc_i`  in  32  PC to save; sampled on acceptance.
- `clear_i`  in  1  invalidates the checkpoint; aborts an in-progress capture.
- `rf_raddr_o`  out  5  register-file read address.
- `rf_rdata_i`  in  32  register-file data, valid one cycle after `rf_raddr_o`.
- `ckpt_busy_o`  out  1  high while capturing.
- `ckpt_done_o`  out  1  one-cycle pulse on capture completion.
- `ckpt_valid_o`  out  1  save area holds a complete checkpoint.
- `req_i`  in  1  bus read/write request.
- `we_i`  in  1  bus write enable (see Configuration).
- `addr_i`  in  32  bus byte address.
- `wdata_i`  in  32  bus write data.
- `rdata_o`  out  32  bus read data.
- `rvalid_o`  out  1  response valid, one cycle after `req_i`.

## Operation

- Save layout: entry k (0..30) at `SAVE_BASE`+4k holds x(k+1); entry 31 (`SAVE_BASE`+0x7C) holds the PC.
- FSM states: IDLE, READ, DRAIN.
  - IDLE: on `ckpt_req_i`, write `pc_i` to entry 31, load counter = 1, clear `ckpt_valid_o`, go to READ.
  - READ: `rf_raddr_o` = counter; write `rf_rdata_i` to entry counter−2 when counter ≥ 2; increment the counter. After issuing address 31, go to DRAIN.
  - DRAIN: write `rf_rdata_i` to entry 30, pulse `ckpt_done_o`, set `ckpt_valid_o`, go to IDLE.
- `ckpt_busy_o` = (state != IDLE). `ckpt_req_i` is ignored while busy; no queuing.
- `clear_i` has priority over everything: go to IDLE and clear `ckpt_valid_o`. No done pulse. Entries already written keep their values.
- Bus hit: `addr_i[31:7]` == `SAVE_BASE[31:7]`. Index = `addr_i[6:2]`; `addr_i[1:0]` is ignored.
- Read response: on a hit, `rdata_o` = entry; on a miss, 0. Reads are allowed during capture and return current contents.
- `rf_raddr_o` is 0 outside READ.

## Timing

- Capture is accepted in cycle T. `rf_raddr_o` = 1..31 during T+1..T+31. Entries 0..30 are written at the ends of T+2..T+32. `ckpt_done_o` and `ckpt_valid_o` rise in cycle T+33. Total latency is 33 cycles.
- Bus: `req_i` in cycle N gives `rvalid_o` = 1 and `rdata_o` in cycle N+1. Address and data are registered. Back-to-back requests are allowed every cycle.
- A bus read of an entry in the same cycle that entry is written by capture returns the old value.
- Reset values: state IDLE; `ckpt_busy_o`, `ckpt_done_o`, `ckpt_valid_o`, `rvalid_o` = 0; `rdata_o` = 0; `rf_raddr_o` = 0. Save entries are not reset.
- Reset mid-capture behaves like `clear_i`.

## Configuration

- `RECOVERY_SAVE_BUS_WRITE_EN` defined: a bus write (`req_i` && `we_i`, hit, state IDLE) writes `wdata_i` to the indexed entry. The write does not change `ckpt_valid_o`. Bus writes during capture are dropped. A write request still produces `rvalid_o`, with `rdata_o` = the old entry value.
- Not defined: `we_i` and `wdata_i` are ignored. Every request is a read.

## Test plan

- Preload the register file with xn = 0xA000_0000+n and set `pc_i` = 0x0000_0200; pulse `ckpt_req_i` -> `ckpt_done_o` at T+33. Bus reads at 0x1000_0080..0x1000_00F8 return 0xA000_0001..0xA000_001F; a read at 0x1000_00FC returns 0x0000_0200.
- Read at 0x1000_0000 and at 0x1000_0100 -> `rdata_o` = 0, `rvalid_o` = 1 one cycle later.
- Assert `clear_i` at T+10 -> busy drops next cycle, no done pulse, `ckpt_valid_o` = 0. Entries 0..7 are updated; entries 8..30 hold their old values.
- Second `ckpt_req_i` at T+5 -> ignored. Done still at T+33 and only one done pulse.
- Assert `rst_i` mid-capture -> all outputs 0 next cycle. A new request afterwards completes normally in 33 cycles.
- With `RECOVERY_SAVE_BUS_WRITE_EN`: write 0xDEAD_BEEF to 0x1000_0084, then read it back -> 0xDEAD_BEEF. Without the macro -> the old value.

Source files
------------

// File: rtl/recovery_state_store.sv
// Checkpoint save area: captures x1..x31 and the PC into 32 words and serves them on the data bus.
// Optional RECOVERY_SAVE_BUS_WRITE_EN lets the bus write entries while no capture is running.
module recovery_state_store #(
  parameter logic [31:0] SAVE_BASE = 32'h1000_0080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ckpt_req_i,
  input  logic [31:0] pc_i,
  input  logic        clear_i,
  output logic [4:0]  rf_raddr_o,
  input  logic [31:0] rf_rdata_i,
  output logic        ckpt_busy_o,
  output logic        ckpt_done_o,
  output logic        ckpt_valid_o,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        rvalid_o
);

  localparam int unsigned AW        = 5;
  localparam int unsigned DW        = 32;
  localparam int unsigned N_ENTRIES = 32;
  localparam logic [AW-1:0] PC_IDX    = AW'(31);
  localparam logic [AW-1:0] LAST_REG  = AW'(31);
  localparam logic [AW-1:0] LAST_ENT  = AW'(30);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   raddr_q, raddr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            valid_q, valid_d;
  logic            rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [DW-1:0]   save_q [N_ENTRIES];

  logic            wr_en;
  logic [AW-1:0]   wr_idx;
  logic [DW-1:0]   wr_data;
  logic            bus_hit;
  logic [AW-1:0]   bus_idx;
  logic            bus_wr;

  assign bus_hit = (addr_i[31:7] == SAVE_BASE[31:7]);
  assign bus_idx = addr_i[6:2];

`ifdef RECOVERY_SAVE_BUS_WRITE_EN
  assign bus_wr = req_i && we_i && bus_hit && (state_q == IDLE);
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[1:0];
`else
  assign bus_wr = 1'b0;
  logic unused_bus_inputs;
  assign unused_bus_inputs = ^{addr_i[1:0], we_i, wdata_i};
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; clear overrides every transition
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ckpt_req_i) state_d = READ;
        READ:    if (cnt_q == LAST_REG) state_d = DRAIN;
        DRAIN:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs, counter and save-area write port
  always_comb begin
    cnt_d   = cnt_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    if (clear_i) begin
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ckpt_req_i) begin
            wr_en   = 1'b1;
            wr_idx  = PC_IDX;
            wr_data = pc_i;
            cnt_d   = AW'(1);
            valid_d = 1'b0;
          end else if (bus_wr) begin
            wr_en   = 1'b1;
            wr_idx  = bus_idx;
            wr_data = wdata_i;
          end
        end
        READ: begin
          // Data returned now belongs to the address issued last cycle (cnt_q-1 -> entry cnt_q-2)
          if (cnt_q >= AW'(2)) begin
            wr_en   = 1'b1;
            wr_idx  = AW'(cnt_q - AW'(2));
            wr_data = rf_rdata_i;
          end
          cnt_d = AW'(cnt_q + AW'(1));
        end
        DRAIN: begin
          wr_en   = 1'b1;
          wr_idx  = LAST_ENT;
          wr_data = rf_rdata_i;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end
        default: ;
      endcase
    end
    busy_d   = (state_d != IDLE);
    raddr_d  = (state_d == READ) ? cnt_d : '0;
    rvalid_d = req_i;
    rdata_d  = (req_i && bus_hit) ? save_q[bus_idx] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      raddr_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      raddr_q  <= raddr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Save entries are intentionally not reset
  always_ff @(posedge clk_i) begin
    if (wr_en) save_q[wr_idx] <= wr_data;
  end

  assign rf_raddr_o   = raddr_q;
  assign ckpt_busy_o  = busy_q;
  assign ckpt_done_o  = done_q;
  assign ckpt_valid_o = valid_q;
  assign rvalid_o     = rvalid_q;
  assign rdata_o      = rdata_q;

endmodule
